// File: rtl/wash_led_panel_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg: shared definitions for the washing-machine LED panel.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - default blink timing
//   - per-LED thermometer / one-hot bit rules, used inside generate loops so
//     every LED vector is built at exactly its own width
// -----------------------------------------------------------------------------
package wash_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_OFF    = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int BLINK_HALF_DEF    = 500;
    localparam int FINISH_BLINKS_DEF = 5;

    // Thermometer, LSB first: LED i is lit when the level exceeds i.
    // A level above the vector width simply lights every LED, which gives
    // the min(level, width) clamp for free.
    function automatic logic therm_bit(input logic [4:0] n, input int unsigned i);
        return ({27'd0, n} > i);
    endfunction

    // One-hot: LED i is lit only when idx == i. An index at or beyond the
    // vector width matches no LED, so the vector reads all zeros.
    function automatic logic onehot_bit(input logic [3:0] idx, input int unsigned i);
        return ({28'd0, idx} == i);
    endfunction

endpackage

// File: rtl/wash_led_panel_if.sv
// -----------------------------------------------------------------------------
// wash_led_panel_if: bundle of the panel's functional signals.
//   master : the controller side driving the panel (time, level, stage, finish)
//   slave  : the panel side producing the LED outputs
// clk and reset are kept outside the bundle.
// -----------------------------------------------------------------------------
interface wash_led_panel_if #(
    parameter int NUM_LEDS   = 8,
    parameter int NUM_STAGES = 4,
    parameter int TIME_W     = 6
);
    logic                  tick_khz;
    logic                  power_off;
    logic                  if_finish;
    logic [3:0]            counter_power;
    logic [3:0]            water_level;
    logic [TIME_W-1:0]     time_now;
    logic [TIME_W-1:0]     time_all;
    logic [NUM_LEDS-1:0]   bar;
    logic [NUM_LEDS-1:0]   level_led;
    logic [NUM_STAGES-1:0] stage_led;
    logic [7:0]            count;
    logic                  busy;

    modport master (
        output tick_khz, power_off, if_finish, counter_power, water_level,
               time_now, time_all,
        input  bar, level_led, stage_led, count, busy
    );

    modport slave (
        input  tick_khz, power_off, if_finish, counter_power, water_level,
               time_now, time_all,
        output bar, level_led, stage_led, count, busy
    );
endinterface

// File: rtl/wash_led_panel_div.sv
// -----------------------------------------------------------------------------
// wash_progress_div: sequential restoring divider computing
//   quotient = floor(dividend * SCALE / divisor), saturated to SCALE when
//   dividend >= divisor (this also covers divisor == 0).
// Ports:
//   clk      - clock
//   clr      - synchronous clear, returns the divider to idle
//   start    - load operands; also aborts and restarts a running divide
//   dividend - elapsed time
//   divisor  - total time
//   quotient - result, valid while done is high
//   busy     - divide in progress
//   done     - one-cycle pulse when quotient is final
// Since the unsaturated result is below SCALE, only $clog2(SCALE) quotient
// bits are produced, one per cycle, against a pre-shifted divisor.
// -----------------------------------------------------------------------------
module wash_progress_div #(
    parameter int TIME_W = 6,
    parameter int SCALE  = 8,
    parameter int QUO_W  = $clog2(SCALE + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [TIME_W-1:0] dividend,
    input  logic [TIME_W-1:0] divisor,
    output logic [QUO_W-1:0]  quotient,
    output logic              busy,
    output logic              done
);
    localparam int QW = $clog2(SCALE);
    localparam int W  = TIME_W + QUO_W;
    localparam int CW = $clog2(QW + 1);

    logic [W-1:0]     rem_q, den_q;
    logic [QUO_W-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;
    logic             ge;

    assign ge = (rem_q >= den_q);

    always_ff @(posedge clk) begin
        if (clr) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            if (dividend >= divisor) begin
                // saturated: no steps, finish on the next cycle
                quo_q <= QUO_W'(SCALE);
                cnt_q <= '0;
                rem_q <= '0;
                den_q <= '0;
            end else begin
                quo_q <= '0;
                cnt_q <= CW'(QW);
                rem_q <= W'(dividend) * W'(SCALE);
                den_q <= W'(divisor) << (QW - 1);
            end
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                if (ge) rem_q <= rem_q - den_q;
                quo_q <= {quo_q[QUO_W-2:0], ge};
                den_q <= den_q >> 1;
                cnt_q <= cnt_q - CW'(1);
            end
            if (cnt_q <= CW'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quotient = quo_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: rtl/wash_led_panel.sv
// -----------------------------------------------------------------------------
// wash_led_panel: LED panel controller for a washing machine.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   tick_khz       - 1 kHz one-cycle enable, paces the finish blink
//   power_off      - panel off, overrides everything except reset
//   if_finish      - wash complete (level)
//   counter_power  - current stage index -> stage_led one-hot
//   water_level    - water level -> level_led thermometer
//   time_now/all   - elapsed/total time -> bar progress thermometer
//   bar            - progress in RUN, blinking in FINISH, solid in DONE
//   level_led      - water thermometer
//   stage_led      - one-hot stage
//   count          - finish on-phases counted (saturating)
//   busy           - progress divider running
// -----------------------------------------------------------------------------
module wash_led_panel
    import wash_pkg::*;
#(
    parameter int NUM_LEDS      = 8,
    parameter int NUM_STAGES    = 4,
    parameter int TIME_W        = 6,
    parameter int BLINK_HALF    = BLINK_HALF_DEF,
    parameter int FINISH_BLINKS = FINISH_BLINKS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_khz,
    input  logic                  power_off,
    input  logic                  if_finish,
    input  logic [3:0]            counter_power,
    input  logic [3:0]            water_level,
    input  logic [TIME_W-1:0]     time_now,
    input  logic [TIME_W-1:0]     time_all,
    output logic [NUM_LEDS-1:0]   bar,
    output logic [NUM_LEDS-1:0]   level_led,
    output logic [NUM_STAGES-1:0] stage_led,
    output logic [7:0]            count,
    output logic                  busy
);
    localparam int QUO_W = $clog2(NUM_LEDS + 1);
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    state_t                state_q, state_d;
    logic [NUM_LEDS-1:0]   bar_q, bar_d;
    logic [NUM_LEDS-1:0]   lvl_q, lvl_now;
    logic [NUM_STAGES-1:0] stg_q, stg_now;
    logic [7:0]            cnt_q, cnt_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic [NUM_LEDS-1:0]   prog_q, prog_now, prog_therm;
    logic [TIME_W-1:0]     tn_q, ta_q;
    logic                  kick_q;

    logic                  active, changed, half_end;
    logic                  div_clr, div_start, div_busy, div_done;
    logic [QUO_W-1:0]      div_quo;

    assign active   = (state_q != ST_OFF);
    // kick_q forces one divide after power-up even if the times equal the
    // cleared samples (e.g. 0/0 must still light the whole bar).
    assign changed  = kick_q || (time_now != tn_q) || (time_all != ta_q);
    assign div_clr  = reset || power_off;
    assign div_start = active && changed;
    assign half_end = tick_khz && (blk_q == BLK_W'(BLINK_HALF - 1));

    wash_progress_div #(
        .TIME_W (TIME_W),
        .SCALE  (NUM_LEDS),
        .QUO_W  (QUO_W)
    ) u_div (
        .clk      (clk),
        .clr      (div_clr),
        .start    (div_start),
        .dividend (time_now),
        .divisor  (time_all),
        .quotient (div_quo),
        .busy     (div_busy),
        .done     (div_done)
    );

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        assign prog_therm[i] = therm_bit(5'(div_quo), i);
        assign lvl_now[i]    = therm_bit({1'b0, water_level}, i);
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        assign stg_now[i] = onehot_bit(counter_power, i);
    end

    // Progress pattern: fresh result on the done pulse, otherwise the last one.
    assign prog_now = div_done ? prog_therm : prog_q;

    always_comb begin
        state_d = state_q;
        bar_d   = bar_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        if (power_off) begin
            state_d = ST_OFF;
            bar_d   = '0;
            cnt_d   = '0;
            blk_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_RUN;
                    bar_d   = '0;
                end
                ST_RUN: begin
                    if (if_finish) begin
                        state_d = ST_FINISH;
                        bar_d   = '1;
                        cnt_d   = '0;
                        blk_d   = '0;
                    end else begin
                        bar_d = prog_now;
                    end
                end
                ST_FINISH: begin
                    if (!if_finish) begin
                        state_d = ST_RUN;
                        bar_d   = prog_now;
                        blk_d   = '0;
                    end else if (half_end) begin
                        blk_d = '0;
                        if (bar_q[0]) begin
                            // end of an on-phase: stop once enough were counted
                            if (cnt_q >= 8'(FINISH_BLINKS)) state_d = ST_DONE;
                            else                            bar_d   = '0;
                        end else begin
                            bar_d = '1;
                            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                        end
                    end else if (tick_khz) begin
                        blk_d = blk_q + BLK_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!if_finish) begin
                        state_d = ST_RUN;
                        bar_d   = prog_now;
                    end else begin
                        bar_d = '1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OFF;
            bar_q   <= '0;
            lvl_q   <= '0;
            stg_q   <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            prog_q  <= '0;
            tn_q    <= '0;
            ta_q    <= '0;
            kick_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bar_q   <= bar_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            lvl_q   <= power_off ? '0 : lvl_now;
            stg_q   <= power_off ? '0 : stg_now;
            if (power_off || !active) begin
                prog_q <= '0;
                tn_q   <= '0;
                ta_q   <= '0;
                kick_q <= 1'b1;
            end else begin
                prog_q <= prog_now;
                if (changed) begin
                    tn_q   <= time_now;
                    ta_q   <= time_all;
                    kick_q <= 1'b0;
                end
            end
        end
    end

    assign bar       = bar_q;
    assign level_led = lvl_q;
    assign stage_led = stg_q;
    assign count     = cnt_q;
    assign busy      = div_busy;

endmodule

// File: tb/tb_wash_led_panel.sv
// -----------------------------------------------------------------------------
// tb_wash_led_panel: directed bench for wash_led_panel with NUM_LEDS=8,
// NUM_STAGES=4, TIME_W=6, BLINK_HALF=2, FINISH_BLINKS=5.
// -----------------------------------------------------------------------------
module tb_wash_led_panel;

    logic clk;
    logic reset;

    wash_led_panel_if #(.NUM_LEDS(8), .NUM_STAGES(4), .TIME_W(6)) pif ();

    wash_led_panel #(
        .NUM_LEDS      (8),
        .NUM_STAGES    (4),
        .TIME_W        (6),
        .BLINK_HALF    (2),
        .FINISH_BLINKS (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_khz      (pif.tick_khz),
        .power_off     (pif.power_off),
        .if_finish     (pif.if_finish),
        .counter_power (pif.counter_power),
        .water_level   (pif.water_level),
        .time_now      (pif.time_now),
        .time_all      (pif.time_all),
        .bar           (pif.bar),
        .level_led     (pif.level_led),
        .stage_led     (pif.stage_led),
        .count         (pif.count),
        .busy          (pif.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] wl;
        logic [3:0] cp;
        logic [5:0] tn;
        logic [5:0] ta;
        logic [7:0] e_bar;
        logic [7:0] e_lvl;
        logic [3:0] e_stg;
    } vec_t;

    vec_t vecs[8];
    int   tests = 0;
    int   fails = 0;

    // advance n clock edges, then settle 1 time unit past the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        pif.tick_khz = 1'b1;
        step(1);
        pif.tick_khz = 1'b0;
        step(1);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp_v);
        end
    endtask

    initial begin
        logic seen_busy;
        logic ok;

        //            wl     cp     tn      ta      bar     lvl     stg
        vecs[0] = '{4'd2,  4'd0,  6'd11, 6'd29, 8'h07, 8'h03, 4'h1};
        vecs[1] = '{4'd12, 4'd1,  6'd29, 6'd29, 8'hFF, 8'hFF, 4'h2};
        vecs[2] = '{4'd0,  4'd5,  6'd5,  6'd0,  8'hFF, 8'h00, 4'h0};
        vecs[3] = '{4'd8,  4'd3,  6'd0,  6'd40, 8'h00, 8'hFF, 4'h8};
        vecs[4] = '{4'd7,  4'd2,  6'd62, 6'd63, 8'h7F, 8'h7F, 4'h4};
        vecs[5] = '{4'd1,  4'd15, 6'd1,  6'd8,  8'h01, 8'h01, 4'h0};
        vecs[6] = '{4'd4,  4'd4,  6'd20, 6'd40, 8'h0F, 8'h0F, 4'h0};
        vecs[7] = '{4'd9,  4'd2,  6'd63, 6'd5,  8'hFF, 8'hFF, 4'h4};

        reset             = 1'b1;
        pif.tick_khz      = 1'b0;
        pif.power_off     = 1'b1;
        pif.if_finish     = 1'b0;
        pif.counter_power = 4'd0;
        pif.water_level   = 4'd0;
        pif.time_now      = 6'd0;
        pif.time_all      = 6'd0;
        step(2);
        chk("reset_bar",   32'(pif.bar),       32'h0);
        chk("reset_level", 32'(pif.level_led), 32'h0);
        chk("reset_stage", 32'(pif.stage_led), 32'h0);
        chk("reset_count", 32'(pif.count),     32'h0);
        chk("reset_busy",  32'(pif.busy),      32'h0);

        // power-up progress: 11*8/29 -> P=3 within 10 cycles
        reset         = 1'b0;
        pif.power_off = 1'b0;
        pif.time_now  = 6'd11;
        pif.time_all  = 6'd29;
        seen_busy = 1'b0;
        ok        = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step(1);
            if (pif.busy) seen_busy = 1'b1;
            if (pif.bar == 8'h07 && !pif.busy) ok = 1'b1;
        end
        chk("startup_bar",  32'(pif.bar),  32'h07);
        chk("startup_busy_seen", 32'(seen_busy), 32'h1);
        chk("startup_busy_low",  32'(pif.busy),  32'h0);

        // level/stage registered with one cycle of latency
        pif.water_level   = 4'd2;
        pif.counter_power = 4'd0;
        step(1);
        chk("lat_level", 32'(pif.level_led), 32'h03);
        chk("lat_stage", 32'(pif.stage_led), 32'h1);
        pif.water_level = 4'd12;
        step(1);
        chk("lat_level_clamp", 32'(pif.level_led), 32'hFF);
        pif.counter_power = 4'd5;
        step(1);
        chk("lat_stage_oob", 32'(pif.stage_led), 32'h0);

        for (int i = 0; i < 8; i++) begin
            pif.water_level   = vecs[i].wl;
            pif.counter_power = vecs[i].cp;
            pif.time_now      = vecs[i].tn;
            pif.time_all      = vecs[i].ta;
            step(12);
            chk($sformatf("vec%0d_bar", i),   32'(pif.bar),       32'(vecs[i].e_bar));
            chk($sformatf("vec%0d_level", i), 32'(pif.level_led), 32'(vecs[i].e_lvl));
            chk($sformatf("vec%0d_stage", i), 32'(pif.stage_led), 32'(vecs[i].e_stg));
            chk($sformatf("vec%0d_busy", i),  32'(pif.busy),      32'h0);
        end

        // input change mid-divide: 10/40 aborted, 30/40 -> P=6
        pif.time_now = 6'd10;
        pif.time_all = 6'd40;
        step(2);
        chk("mid_busy", 32'(pif.busy), 32'h1);
        pif.time_now = 6'd30;
        step(12);
        chk("mid_restart_bar", 32'(pif.bar), 32'h3F);

        // finish blink sequence
        pif.time_now      = 6'd20;
        pif.time_all      = 6'd40;
        pif.water_level   = 4'd3;
        pif.counter_power = 4'd2;
        step(12);
        chk("run_bar", 32'(pif.bar), 32'h0F);
        pif.if_finish = 1'b1;
        step(1);
        chk("fin_entry_bar", 32'(pif.bar),   32'hFF);
        chk("fin_entry_cnt", 32'(pif.count), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            tick();
            chk($sformatf("blink%0d_off", k), 32'(pif.bar), 32'h00);
            tick();
            tick();
            chk($sformatf("blink%0d_on", k),  32'(pif.bar),   32'hFF);
            chk($sformatf("blink%0d_cnt", k), 32'(pif.count), 32'(k));
        end
        tick();
        tick();
        chk("done_bar", 32'(pif.bar), 32'hFF);
        tick();
        tick();
        chk("done_steady", 32'(pif.bar),   32'hFF);
        chk("done_count",  32'(pif.count), 32'h5);

        pif.if_finish = 1'b0;
        step(1);
        chk("restore_bar", 32'(pif.bar),   32'h0F);
        chk("count_hold",  32'(pif.count), 32'h5);

        // power_off during FINISH, with if_finish still high
        pif.if_finish = 1'b1;
        step(1);
        chk("refinish_cnt", 32'(pif.count), 32'h0);
        tick();
        pif.power_off = 1'b1;
        step(1);
        chk("poff_bar",   32'(pif.bar),       32'h0);
        chk("poff_level", 32'(pif.level_led), 32'h0);
        chk("poff_stage", 32'(pif.stage_led), 32'h0);
        chk("poff_count", 32'(pif.count),     32'h0);
        chk("poff_busy",  32'(pif.busy),      32'h0);

        // power back on, then reset in the middle of a divide
        pif.power_off = 1'b0;
        pif.if_finish = 1'b0;
        step(10);
        chk("pwr_on_bar",   32'(pif.bar),       32'h0F);
        chk("pwr_on_level", 32'(pif.level_led), 32'h07);
        pif.time_now = 6'd40;
        step(1);
        chk("rst_mid_busy", 32'(pif.busy), 32'h1);
        reset = 1'b1;
        step(1);
        chk("rst_mid_busy_clr", 32'(pif.busy),      32'h0);
        chk("rst_mid_bar",      32'(pif.bar),       32'h0);
        chk("rst_mid_level",    32'(pif.level_led), 32'h0);
        chk("rst_mid_stage",    32'(pif.stage_led), 32'h0);
        reset = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
